// File: rtl/sync_rx_pkg.sv
// rtl/sync_rx_pkg.sv - shared defaults and FSM encoding for the toggle-handshake RX half
package sync_rx_pkg;

    localparam int WIDTH_DEF    = 8;
    localparam int STAGES_DEF   = 2;
    localparam int XFER_COUNT_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } rx_state_e;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - STAGES-deep single-bit synchroniser, async active-high reset to 0
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/sync_rx.sv
// rtl/sync_rx.sv - RX half of toggle double-handshake synchroniser; optional SYNC_RX_XFER_COUNT_EN
module sync_rx
    import sync_rx_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STAGES = STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx,
    input  logic [WIDTH-1:0] data,
    output logic             rx_a,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    input  logic             ready
`ifdef SYNC_RX_XFER_COUNT_EN
    ,
    output logic [XFER_COUNT_W-1:0] xfer_count
`endif
);

    rx_state_e        state_q, state_d;
    logic             rx_a_q, rx_a_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             tx_s;
    logic             pending;
    logic             slot_free;
    logic             capture;

    sync_ff #(.STAGES(STAGES)) u_tx_sync (
        .clk (clk),
        .rst (rst),
        .d   (tx),
        .q   (tx_s)
    );

    // data is only trusted while a request is pending: TX holds it stable until acked
    assign pending   = tx_s ^ rx_a_q;
    assign slot_free = (state_q == ST_IDLE) || ready;
    assign capture   = pending && slot_free;

    always_comb begin
        state_d = state_q;
        rx_a_d  = rx_a_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: if (capture) state_d = ST_FULL;
            ST_FULL: if (ready && !pending) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (capture) begin
            out_d  = data;
            rx_a_d = ~rx_a_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rx_a_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            rx_a_q  <= rx_a_d;
            out_q   <= out_d;
        end
    end

    assign rx_a  = rx_a_q;
    assign out   = out_q;
    assign valid = (state_q == ST_FULL);

`ifdef SYNC_RX_XFER_COUNT_EN
    logic [XFER_COUNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (capture) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign xfer_count = cnt_q;
`endif

endmodule

// File: tb/tb_sync_rx.sv
// tb/tb_sync_rx.sv - scoreboard bench for sync_rx
module tb_sync_rx;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tx = 1'b0;
    logic [WIDTH-1:0] data = '0;
    logic             rx_a;
    logic [WIDTH-1:0] out;
    logic             valid;
    logic             ready = 1'b1;
`ifdef SYNC_RX_XFER_COUNT_EN
    logic [15:0]      xfer_count;
`endif

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned accepts = 0;
    logic [7:0]  acc8 = '0;
    logic [WIDTH-1:0] exp_q[$];

    always #5 clk = ~clk;

    sync_rx #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk   (clk),
        .rst   (rst),
        .tx    (tx),
        .data  (data),
        .rx_a  (rx_a),
        .out   (out),
        .valid (valid),
        .ready (ready)
`ifdef SYNC_RX_XFER_COUNT_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // consumer side: every accepted word must be the oldest outstanding one
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            accepts++;
            acc8 <= acc8 + 8'd1;
            if (exp_q.size() == 0) chk("unexpected_word", {24'd0, out}, 32'hFFFF_FFFF);
            else                   chk("out_word", {24'd0, out}, {24'd0, exp_q.pop_front()});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // TX model: wait for previous ack, then present word and toggle request
    task automatic send(input logic [WIDTH-1:0] w);
        int guard = 0;
        while (rx_a !== tx && guard < 200) begin
            step(1);
            guard++;
        end
        if (guard >= 200) chk("ack_timeout", 32'd0, 32'd1);
        data = w;
        tx   = ~tx;
        exp_q.push_back(w);
    endtask

    task automatic wait_valid(input string tag);
        int guard = 0;
        while (valid !== 1'b1 && guard < 50) begin
            step(1);
            guard++;
        end
        if (guard >= 50) chk(tag, 32'd0, 32'd1);
    endtask

    logic rx_a_hold;
    int   acc_before;

    initial begin
        data  = 8'h5A;
        ready = 1'b1;
        step(2);
        #2 rst = 1'b0;
        step(1);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_rx_a", {31'd0, rx_a}, 32'd0);
        chk("rst_out", {24'd0, out}, 32'h00);
        step(10);
        chk("idle_valid", {31'd0, valid}, 32'd0);
        chk("idle_rx_a", {31'd0, rx_a}, 32'd0);
        chk("idle_out", {24'd0, out}, 32'h00);

        // latency: toggle between edges, word visible after STAGES+1 edges
        send(8'hA5);
        for (int e = 1; e <= STAGES; e++) begin
            step(1);
            chk("lat_valid_early", {31'd0, valid}, 32'd0);
            chk("lat_rx_a_early", {31'd0, rx_a}, 32'd0);
        end
        step(1);
        chk("lat_valid", {31'd0, valid}, 32'd1);
        chk("lat_out", {24'd0, out}, 32'hA5);
        chk("lat_rx_a", {31'd0, rx_a}, 32'd1);
        step(1);
        chk("lat_pop", {31'd0, valid}, 32'd0);

        // backpressure: second request must not be acked until the slot frees
        ready = 1'b0;
        send(8'h11);
        wait_valid("bp_first_timeout");
        chk("bp_first_out", {24'd0, out}, 32'h11);
        send(8'h22);
        rx_a_hold = rx_a;
        step(12);
        chk("bp_rx_a_held", {31'd0, rx_a}, {31'd0, rx_a_hold});
        chk("bp_out_held", {24'd0, out}, 32'h11);
        chk("bp_valid_held", {31'd0, valid}, 32'd1);
        ready = 1'b1;
        step(1);
        chk("bp_swap_out", {24'd0, out}, 32'h22);
        chk("bp_swap_valid", {31'd0, valid}, 32'd1);
        chk("bp_swap_ack", {31'd0, rx_a}, {31'd0, ~rx_a_hold});
        step(1);
        chk("bp_drain", {31'd0, valid}, 32'd0);

        // streaming 0x00..0xFF
        acc_before = accepts;
        for (int i = 0; i < 256; i++) send(i[7:0]);
        step(10);
        chk("stream_count", accepts - acc_before, 32'd256);
        chk("stream_empty", exp_q.size(), 32'd0);
        chk("stream_acc8", {24'd0, acc8 - 8'(acc_before)}, 32'd0);

`ifdef SYNC_RX_XFER_COUNT_EN
        chk("xfer_count", {16'd0, xfer_count}, accepts);
`endif

        // reset while FULL discards the held word
        ready = 1'b0;
        send(8'h33);
        wait_valid("rst_full_timeout");
        chk("rst_full_out", {24'd0, out}, 32'h33);
        void'(exp_q.pop_front());
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_valid", {31'd0, valid}, 32'd0);
        chk("async_rx_a", {31'd0, rx_a}, 32'd0);
        chk("async_out", {24'd0, out}, 32'h00);
        tx   = 1'b1;
        data = 8'h3C;
        exp_q.push_back(8'h3C);
        step(2);
        rst   = 1'b0;
        ready = 1'b1;
        acc_before = accepts;
        step(20);
        chk("recapture_once", accepts - acc_before, 32'd1);
        chk("recapture_empty", exp_q.size(), 32'd0);
        chk("recapture_ack", {31'd0, rx_a}, 32'd1);
`ifdef SYNC_RX_XFER_COUNT_EN
        chk("xfer_count_rst", {16'd0, xfer_count}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1);
    end

endmodule
